// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Sequential radix-2 Booth multiplier for two's-complement operands.
// One Booth add/subtract plus one arithmetic right shift per CALC cycle.
// The result comes out WIDTH cycles after the operation starts.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// CALC  | iterating Booth steps (busy=1)
// DONE  | product valid, done=1 for one cycle; start accepted here too
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   start    in   request; sampled only in IDLE or DONE
//   a        in   signed multiplicand, captured on accepted start
//   b        in   signed multiplier, captured on accepted start
//   busy     out  high while iterating
//   done     out  one-cycle pulse, product valid
//   product  out  signed a*b, held until the next result
module booth_multiplier_seq #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [WIDTH:0]   acc;
    logic signed [WIDTH:0]   m;
    logic        [WIDTH-1:0] q;
    logic                    q_m1;
    logic        [CW-1:0]    cnt;

    logic signed [WIDTH:0]   acc_step;
    logic signed [WIDTH:0]   acc_new;
    logic        [WIDTH-1:0] q_new;
    logic                    accept;
    logic                    last_step;

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_step = (cnt == CW'(WIDTH - 1));

    // Booth recoding of {q[0], q_m1}: 01 adds m, 10 subtracts m.
    always_comb begin
        acc_step = acc;
        unique case ({q[0], q_m1})
            2'b01:   acc_step = acc + m;
            2'b10:   acc_step = acc - m;
            default: acc_step = acc;
        endcase
    end

    // Arithmetic right shift of {acc_step, q, q_m1}; acc_step[WIDTH] replicates.
    assign acc_new = {acc_step[WIDTH], acc_step[WIDTH:1]};
    assign q_new   = {acc_step[0], q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start)     state_nxt = ST_CALC;
            ST_CALC: if (last_step) state_nxt = ST_DONE;
            ST_DONE: state_nxt = start ? ST_CALC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Flags follow the next state so they come straight from flops.
            busy <= (state_nxt == ST_CALC);
            done <= (state_nxt == ST_DONE);
            if (accept) begin
                m    <= {a[WIDTH-1], a};
                q    <= b;
                acc  <= '0;
                q_m1 <= 1'b0;
                cnt  <= '0;
            end else if (state == ST_CALC) begin
                acc  <= acc_new;
                q    <= q_new;
                q_m1 <= q[0];
                cnt  <= cnt + CW'(1);
                // acc_new[WIDTH] always equals acc_new[WIDTH-1] here, so dropping it is exact.
                if (last_step) begin
                    product <= {acc_new[WIDTH-1:0], q_new};
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
module tb_booth_multiplier_seq;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic              busy;
    logic              done;
    logic signed [7:0] product;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        int         exp;
        string      name;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    booth_multiplier_seq #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain two's-complement interpretation and integer multiply.
    function automatic int sval(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    task automatic accept(input logic [3:0] va, input logic [3:0] vb);
        a     = va;
        b     = vb;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting edges and busy cycles on the way.
    task automatic wait_done(input int exp, input int exp_lat, input bit scramble,
                             input string tag);
        int n  = 0;
        int bn = 0;
        int ov = 0;
        while (!done && n < 20) begin
            if (busy) bn++;
            if (busy && done) ov++;
            if (scramble) begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            cycle();
            n++;
        end
        if (busy && done) ov++;
        check_eq({tag, " latency"}, n, exp_lat);
        check_eq({tag, " busy_cycles"}, bn, exp_lat);
        check_eq({tag, " busy_and_done"}, ov, 0);
        check_eq({tag, " product"}, int'(product), exp);
    endtask

    task automatic watch_no_done(input int n, input string tag);
        int extra = 0;
        repeat (n) begin
            cycle();
            if (done) extra++;
        end
        check_eq({tag, " no_extra_done"}, extra, 0);
    endtask

    initial begin
        vecs[0] = '{4'd5, 4'd7, 35,  "dir_5x7"};
        vecs[1] = '{4'd1, 4'h8, -8,  "dir_1xm8"};
        vecs[2] = '{4'hD, 4'hA, 18,  "dir_m3xm6"};
        vecs[3] = '{4'hB, 4'd5, -25, "dir_m5x5"};
        vecs[4] = '{4'h8, 4'h8, 64,  "dir_m8xm8"};
        vecs[5] = '{4'd0, 4'hF, 0,   "dir_0xm1"};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cycle();
        cycle();
        check_eq("reset busy", int'(busy), 0);
        check_eq("reset done", int'(done), 0);
        check_eq("reset product", int'(product), 0);

        // Reset and start together: reset wins.
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd3;
        cycle();
        check_eq("rst_start busy", int'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        cycle();
        check_eq("rst_start stays idle", int'(busy), 0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].va, vecs[i].vb);
            wait_done(vecs[i].exp, 4, 1'b0, vecs[i].name);
            cycle();
            check_eq({vecs[i].name, " done_one_cycle"}, int'(done), 0);
            check_eq({vecs[i].name, " product_held"}, int'(product), vecs[i].exp);
        end

        // Exhaustive against the model
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                accept(4'(ai), 4'(bi));
                wait_done(sval(4'(ai)) * sval(4'(bi)), 4, 1'b0, "exh");
                cycle();
            end
        end

        // Random operands, random gaps (including starts taken in DONE)
        repeat (40) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            accept(ra, rb);
            wait_done(sval(ra) * sval(rb), 4, 1'b0, "rand");
            repeat ($urandom_range(0, 2)) cycle();
        end
        cycle();

        // Start during CALC is ignored
        accept(4'd3, 4'd2);
        cycle();
        a     = 4'd7;
        b     = 4'd7;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(6, 2, 1'b0, "calc_start");
        watch_no_done(10, "calc_start");

        // Back-to-back with start held high
        a     = 4'd2;
        b     = 4'd3;
        start = 1'b1;
        cycle();
        a = 4'hC;
        b = 4'd4;
        wait_done(6, 4, 1'b0, "b2b_first");
        cycle();
        check_eq("b2b no_idle busy", int'(busy), 1);
        check_eq("b2b done dropped", int'(done), 0);
        start = 1'b0;
        wait_done(-16, 4, 1'b0, "b2b_second");
        cycle();

        // Reset mid-operation
        accept(4'd7, 4'd7);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("midrst busy", int'(busy), 0);
        check_eq("midrst done", int'(done), 0);
        check_eq("midrst product", int'(product), 0);
        watch_no_done(8, "midrst");
        accept(4'hE, 4'd3);
        wait_done(-6, 4, 1'b0, "after_rst");
        cycle();

        // Operands changing every cycle after acceptance
        accept(4'd4, 4'hD);
        wait_done(-12, 4, 1'b1, "operand_hold");
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
